// File: rtl/masku_mask_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : masku_mask_accumulator
// Description : Packs a stream of SEW-wide comparison results into a
//               1-bit-per-element mask vector. Results are collected over as
//               many datapath beats as needed. Each full (or final partial)
//               mask word is emitted with a per-bit write enable that combines
//               the vl tail with the v0 mask.
// Ports       : clk_i/rst_i    clock, synchronous active-high reset
//               start_i, vl_i, sew_i, vm_i
//                              instruction start and its config (latched)
//               busy_o         instruction in flight
//               in_*           result beats (valid/ready/data/v0 mask)
//               out_*          mask words (valid/ready/data/be/last)
// Revision    : 1.0 - initial release
// ============================================================================
module masku_mask_accumulator #(
    parameter int NR_LANES = 4,
    parameter int ELEN     = 64,
    parameter int VL_WIDTH = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         start_i,
    input  logic [VL_WIDTH-1:0]          vl_i,
    input  logic [1:0]                   sew_i,
    input  logic                         vm_i,
    output logic                         busy_o,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [NR_LANES*ELEN-1:0]     in_data_i,
    input  logic [NR_LANES*ELEN-1:0]     in_mask_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [NR_LANES*ELEN-1:0]     out_data_o,
    output logic [NR_LANES*ELEN-1:0]     out_be_o,
    output logic                         out_last_o
);

    localparam int c_dw    = NR_LANES * ELEN;
    localparam int c_ptr_w = $clog2(c_dw) + 1;   // must hold the value c_dw

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;

    logic [VL_WIDTH-1:0]   r_vl;
    logic [1:0]            r_sew;
    logic                  r_vm;
    logic [c_dw-1:0]       r_acc;
    logic [c_dw-1:0]       r_be;
    logic [c_ptr_w-1:0]    r_ptr;
    logic [VL_WIDTH-1:0]   r_cnt;
    logic                  r_last;

    // Element LSBs for every element width; element k of width SW sits at
    // bit k*SW, so each SEW gives its own compressed result vector.
    logic [3:0][c_dw-1:0]  w_res_all;

    for (genvar s = 0; s < 4; s++) begin : g_sew
        for (genvar k = 0; k < c_dw; k++) begin : g_elem
            if (k < (c_dw >> (3 + s))) begin : g_live
                assign w_res_all[s][k] = in_data_i[k * (8 << s)];
            end else begin : g_pad
                assign w_res_all[s][k] = 1'b0;
            end
        end
    end

    // Only element LSBs are consumed; the remaining result bits are don't-care.
    logic w_unused_data;
    assign w_unused_data = ^in_data_i;

    logic [c_ptr_w-1:0]    w_epb;
    logic [VL_WIDTH-1:0]   w_remain;
    logic [c_ptr_w-1:0]    w_n;
    logic [c_dw-1:0]       w_nmask;
    logic [c_dw-1:0]       w_beat_data;
    logic [c_dw-1:0]       w_beat_be;
    logic [c_ptr_w-1:0]    w_ptr_next;
    logic [VL_WIDTH-1:0]   w_cnt_next;
    logic                  w_word_done;
    logic                  w_beat_hs;

    always_comb begin
        case (r_sew)
            2'd0:    w_epb = c_ptr_w'(c_dw / 8);
            2'd1:    w_epb = c_ptr_w'(c_dw / 16);
            2'd2:    w_epb = c_ptr_w'(c_dw / 32);
            default: w_epb = c_ptr_w'(c_dw / 64);
        endcase

        // cnt never exceeds vl, so the remaining count cannot underflow.
        w_remain = r_vl - r_cnt;
        if (32'(w_remain) < 32'(w_epb)) begin
            w_n = c_ptr_w'(w_remain);
        end else begin
            w_n = w_epb;
        end

        // Keep only the first n elements of the beat; the tail of the final
        // beat is discarded. The accumulator above ptr is always zero, so
        // OR-ing the shifted beat in places it without disturbing earlier bits.
        w_nmask     = ~({c_dw{1'b1}} << w_n);
        w_beat_data = (w_res_all[r_sew] & w_nmask) << r_ptr;
        w_beat_be   = ((r_vm ? {c_dw{1'b1}} : in_mask_i) & w_nmask) << r_ptr;

        w_ptr_next  = r_ptr + w_n;
        w_cnt_next  = r_cnt + VL_WIDTH'(w_n);
        w_word_done = (w_ptr_next == c_ptr_w'(c_dw)) || (w_cnt_next == r_vl);
        w_beat_hs   = (r_state == S_ACCUM) && in_valid_i;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start_i && (vl_i != '0)) begin
                    w_state_next = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (w_beat_hs && w_word_done) begin
                    w_state_next = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (out_ready_i) begin
                    w_state_next = r_last ? S_IDLE : S_ACCUM;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_vl   <= '0;
            r_sew  <= '0;
            r_vm   <= 1'b0;
            r_acc  <= '0;
            r_be   <= '0;
            r_ptr  <= '0;
            r_cnt  <= '0;
            r_last <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i && (vl_i != '0)) begin
                        r_vl   <= vl_i;
                        r_sew  <= sew_i;
                        r_vm   <= vm_i;
                        r_acc  <= '0;
                        r_be   <= '0;
                        r_ptr  <= '0;
                        r_cnt  <= '0;
                        r_last <= 1'b0;
                    end
                end
                S_ACCUM: begin
                    if (w_beat_hs) begin
                        r_acc  <= r_acc | w_beat_data;
                        r_be   <= r_be | w_beat_be;
                        r_ptr  <= w_ptr_next;
                        r_cnt  <= w_cnt_next;
                        r_last <= (w_cnt_next == r_vl);
                    end
                end
                S_FLUSH: begin
                    // Next word starts from a clean slate; cnt carries on.
                    if (out_ready_i && !r_last) begin
                        r_acc <= '0;
                        r_be  <= '0;
                        r_ptr <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy_o      = (r_state != S_IDLE);
    assign in_ready_o  = (r_state == S_ACCUM);
    assign out_valid_o = (r_state == S_FLUSH);
    assign out_data_o  = (r_state == S_FLUSH) ? r_acc : '0;
    assign out_be_o    = (r_state == S_FLUSH) ? r_be  : '0;
    assign out_last_o  = (r_state == S_FLUSH) && r_last;

endmodule
`default_nettype wire

// File: tb/tb_masku_mask_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_masku_mask_accumulator
// Description : Self-checking bench for masku_mask_accumulator. Expected mask
//               words are queued when stimulus is generated and compared when
//               the DUT hands each word over.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_masku_mask_accumulator;

    localparam int DW  = 256;
    localparam int VLW = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [VLW-1:0]  vl;
    logic [1:0]      sew;
    logic            vm;
    logic            busy;
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   in_data;
    logic [DW-1:0]   in_mask;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_data;
    logic [DW-1:0]   out_be;
    logic            out_last;

    always #5 clk = ~clk;

    masku_mask_accumulator #(
        .NR_LANES (4),
        .ELEN     (64),
        .VL_WIDTH (VLW)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .vl_i        (vl),
        .sew_i       (sew),
        .vm_i        (vm),
        .busy_o      (busy),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .in_mask_i   (in_mask),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_be_o    (out_be),
        .out_last_o  (out_last)
    );

    typedef struct {
        logic [DW-1:0] d;
        logic [DW-1:0] be;
        logic          last;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   hs_count = 0;

    // Scoreboard consumer: compares every accepted word with the oldest
    // expectation.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected_word: got out_valid=1 data=%h, required no pending word", out_data);
            end else begin
                m_e = sb.pop_front();
                n_checks++;
                if (out_data !== m_e.d) begin
                    n_fail++;
                    $display("FAIL word_data: got %h required %h", out_data, m_e.d);
                end
                n_checks++;
                if (out_be !== m_e.be) begin
                    n_fail++;
                    $display("FAIL word_be: got %h required %h", out_be, m_e.be);
                end
                n_checks++;
                if (out_last !== m_e.last) begin
                    n_fail++;
                    $display("FAIL word_last: got %b required %b", out_last, m_e.last);
                end
            end
        end
    end

    function automatic logic [DW-1:0] rand_vec();
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic do_start(input int v_len, input int v_sew, input logic v_vm);
        start = 1'b1;
        vl    = VLW'(v_len);
        sew   = 2'(v_sew);
        vm    = v_vm;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic [DW-1:0] m);
        int bound;
        in_valid = 1'b1;
        in_data  = d;
        in_mask  = m;
        bound    = 0;
        @(negedge clk);
        while (!in_ready && bound < 100) begin
            @(negedge clk);
            bound++;
        end
        if (!in_ready) begin
            n_checks++; n_fail++;
            $display("FAIL beat_accept_timeout: got in_ready=0 required 1");
        end else begin
            hs_count++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int bound;
        bound = 0;
        @(negedge clk);
        while (busy && bound < 500) begin
            @(negedge clk);
            bound++;
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_timeout: got busy=%b required 0", busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic check_sb_empty(input string name);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL %s_pending: got %0d words outstanding required 0", name, sb.size());
            sb.delete();
        end
    endtask

    // Generic transaction: builds beats, models the packed words by global
    // element index, queues them, then drives the DUT.
    task automatic run_txn(input int v_len, input int v_sew, input logic v_vm,
                           input int fill, input bit poke);
        int            e, sw, nb, nw;
        logic [DW-1:0] bd[];
        logic [DW-1:0] bm[];
        logic [DW-1:0] wd[];
        logic [DW-1:0] wb[];
        exp_t          x;
        e  = DW >> (3 + v_sew);
        sw = 8 << v_sew;
        nb = (v_len + e - 1) / e;
        nw = (v_len + DW - 1) / DW;
        bd = new[nb];
        bm = new[nb];
        wd = new[nw];
        wb = new[nw];
        for (int b = 0; b < nb; b++) begin
            bd[b] = (fill == 1) ? {DW{1'b1}} : rand_vec();
            bm[b] = rand_vec();
        end
        for (int w = 0; w < nw; w++) begin
            wd[w] = '0;
            wb[w] = '0;
        end
        for (int j = 0; j < v_len; j++) begin
            wd[j / DW][j % DW] = bd[j / e][(j % e) * sw];
            wb[j / DW][j % DW] = v_vm | bm[j / e][j % e];
        end
        for (int w = 0; w < nw; w++) begin
            x.d    = wd[w];
            x.be   = wb[w];
            x.last = (w == nw - 1);
            sb.push_back(x);
        end
        hs_count = 0;
        do_start(v_len, v_sew, v_vm);
        for (int b = 0; b < nb; b++) begin
            if (poke && b == 2) begin
                start = 1'b1;
                vl    = VLW'(5);
            end
            send_beat(bd[b], bm[b]);
            start = 1'b0;
        end
        wait_idle();
        n_checks++;
        if (hs_count != nb) begin
            n_fail++;
            $display("FAIL beat_count: got %0d handshakes required %0d", hs_count, nb);
        end
        check_sb_empty("txn");
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({busy, in_ready, out_valid, out_last} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got busy/in_ready/out_valid/last=%b required 0000",
                     {busy, in_ready, out_valid, out_last});
        end
        n_checks++;
        if (out_data !== '0 || out_be !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got data=%h be=%h required 0", out_data, out_be);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: got busy=%b in_ready=%b required 0 0", busy, in_ready);
        end
    endtask

    task automatic test_single_beat();
        exp_t x;
        x.d = 256'hD; x.be = 256'hF; x.last = 1'b1;
        sb.push_back(x);
        do_start(4, 3, 1'b1);
        send_beat({64'h8000_0000_0000_0001, 64'h3, 64'hFFFF_FFFF_FFFF_FFFE, 64'h5}, '0);
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL single_latency: got out_valid=%b required 1", out_valid);
        end
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_done: got busy=%b out_valid=%b required 0 0", busy, out_valid);
        end
        check_sb_empty("single");
    endtask

    task automatic test_masked();
        exp_t x;
        x.d = 256'hFFFF; x.be = 256'hAAAA; x.last = 1'b1;
        sb.push_back(x);
        do_start(16, 1, 1'b0);
        send_beat({DW{1'b1}}, 256'hAAAA);
        wait_idle();
        check_sb_empty("masked");
    endtask

    task automatic test_backpressure();
        exp_t          x;
        logic [DW-1:0] d;
        d = rand_vec();
        x.d = '0;
        for (int k = 0; k < 8; k++) x.d[k] = d[k * 32];
        x.be = 256'hFF; x.last = 1'b1;
        sb.push_back(x);
        out_ready = 1'b0;
        do_start(8, 2, 1'b1);
        send_beat(d, '0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_ctrl: got out_valid=%b in_ready=%b required 1 0", out_valid, in_ready);
            end
            n_checks++;
            if (out_data !== x.d || out_be !== x.be) begin
                n_fail++;
                $display("FAIL bp_hold: got data=%h be=%h required %h %h", out_data, out_be, x.d, x.be);
            end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release: got busy=%b required 0", busy);
        end
        check_sb_empty("bp");
    endtask

    task automatic test_zero_vl();
        do_start(0, 0, 1'b1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_checks++;
            if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL zero_vl: got busy=%b out_valid=%b in_ready=%b required 000",
                         busy, out_valid, in_ready);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_flush();
        out_ready = 1'b0;
        do_start(4, 3, 1'b1);
        send_beat(rand_vec(), '0);
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rflush_pending: got out_valid=%b required 1", out_valid);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++;
        if ({out_valid, busy, in_ready} !== 3'b000 || out_data !== '0 || out_be !== '0) begin
            n_fail++;
            $display("FAIL rflush_cleared: got valid/busy/ready=%b data=%h required 000 and 0",
                     {out_valid, busy, in_ready}, out_data);
        end
        out_ready = 1'b1;
        run_txn(40, 2, 1'b0, 0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; vl = '0; sew = '0; vm = 1'b0;
        in_valid = 1'b0; in_data = '0; in_mask = '0; out_ready = 1'b1;
        test_reset();
        test_single_beat();
        run_txn(256, 0, 1'b1, 1, 1'b0);   // one full word of ones, 8 beats
        run_txn(300, 0, 1'b1, 0, 1'b0);   // two words, partial tail
        test_masked();
        test_backpressure();
        test_zero_vl();
        run_txn(64, 3, 1'b1, 0, 1'b1);    // start pulse while busy
        test_reset_flush();
        for (int i = 0; i < 4; i++) begin // back-to-back mixed instructions
            run_txn($urandom_range(1, 700), $urandom_range(0, 3), 1'($urandom_range(0, 1)), 0, 1'b0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got simulation still running required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
